// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the cpu16 I/O bus arbiter.
package io_bus_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int unsigned STROBE_CYCLES_DEF = 2;

  // Strobe down-counter width; guarded so an illegal 0 still elaborates far
  // enough to reach the range check in the top.
  function automatic int unsigned cnt_width(input int unsigned sc);
    return (sc < 1) ? 1 : $clog2(sc + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(STROBE_CYCLES_DEF);

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Master request/ack signals plus the shared I/O bus, bundled for the arbiter.
interface io_bus_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_we;
  logic        m1_we;
  logic [15:0] m0_addr;
  logic [15:0] m1_addr;
  logic [15:0] m0_wdata;
  logic [15:0] m1_wdata;
  logic        m0_ack;
  logic        m1_ack;
  logic [15:0] rdata;
  logic [15:0] io_address;
  logic [15:0] io_data_out;
  logic        io_data_oe;
  logic [15:0] io_data_in;
  logic        io_rd;
  logic        io_wr;
  logic        busy;
  logic        grant;

  // Arbiter side
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, io_data_in,
    output m0_ack, m1_ack, rdata, io_address, io_data_out, io_data_oe,
           io_rd, io_wr, busy, grant
  );

  // Masters and bus-side environment
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, io_data_in,
    input  m0_ack, m1_ack, rdata, io_address, io_data_out, io_data_oe,
           io_rd, io_wr, busy, grant
  );
endinterface

// File: rtl/io_rr_arbiter.sv
// Two-way round-robin picker: on a tie the master not served last wins.
module io_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // Pick a winner among active requesters
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) winner = ~last_grant;
    else              winner = req[1];
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the cpu16 I/O bus between two masters: round-robin arbitration,
// transaction latching and registered strobe sequencing.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  io_bus_if.slave  bus
);

  localparam int unsigned    CW       = cnt_width(STROBE_CYCLES);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(STROBE_CYCLES - 1);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("io_bus_arbiter: STROBE_CYCLES must be in 1..15");
  end

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            accept;
  logic            arb_valid, arb_winner;
  logic            last_grant;

  logic            win_we;
  logic [15:0]     win_addr, win_wdata;

  logic            we_q, we_d;
  logic            grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            oe_q, oe_d;
  logic            rd_n_q, rd_n_d;
  logic            wr_n_q, wr_n_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [15:0]     addr_q, wdata_q, rdata_q;

  io_rr_arbiter u_rr (
    .req        ({bus.m1_req, bus.m0_req}),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  // Steer the winning master's transfer fields
  always_comb begin
    win_we    = arb_winner ? bus.m1_we    : bus.m0_we;
    win_addr  = arb_winner ? bus.m1_addr  : bus.m0_addr;
    win_wdata = arb_winner ? bus.m1_wdata : bus.m0_wdata;
  end

  // State register and strobe down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = CNT_LOAD;
      end
      ST_STROBE: begin
        if (cnt == '0) state_d = ST_HOLD;
        else           cnt_d   = cnt - 1'b1;
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a plain flop
  always_comb begin
    we_d    = accept ? win_we     : we_q;
    grant_d = accept ? arb_winner : grant_q;
    busy_d  = (state_d != ST_IDLE);
    oe_d    = busy_d && we_d;
    rd_n_d  = !((state_d == ST_STROBE) && !we_d);
    wr_n_d  = !((state_d == ST_STROBE) &&  we_d);
    ack0_d  = (state_d == ST_HOLD) && !grant_d;
    ack1_d  = (state_d == ST_HOLD) &&  grant_d;
  end

  // Registered outputs, latched transfer and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      grant_q    <= 1'b0;
      busy_q     <= 1'b0;
      oe_q       <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      last_grant <= 1'b1;
    end else begin
      we_q    <= we_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      oe_q    <= oe_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      if (accept) begin
        addr_q <= win_addr;
        if (win_we) wdata_q <= win_wdata;
      end
      if ((state == ST_STROBE) && (cnt == '0) && !we_q) rdata_q <= bus.io_data_in;
      if (state == ST_HOLD) last_grant <= grant_q;
    end
  end

  assign bus.m0_ack      = ack0_q;
  assign bus.m1_ack      = ack1_q;
  assign bus.rdata       = rdata_q;
  assign bus.io_address  = addr_q;
  assign bus.io_data_out = wdata_q;
  assign bus.io_data_oe  = oe_q;
  assign bus.io_rd       = rd_n_q;
  assign bus.io_wr       = wr_n_q;
  assign bus.busy        = busy_q;
  assign bus.grant       = grant_q;

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Shares the cpu16 16-bit I/O bus (io_address, io_data, active-low io_rd/io_wr strobes) between two bus masters, the CPU core and a DMA engine. It arbitrates round-robin, latches the winning transaction, and sequences the strobe timing toward the RAM/peripheral side. It returns read data with a one-cycle acknowledge. It sits between the masters and the bus, replacing direct strobe generation in the masters.

## Interface
- STROBE_CYCLES, 2, cycles io_rd/io_wr are held low; legal range 1..15, 0 is an elaboration error
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- m0_req, m1_req  in  1  master requests a transfer; held until ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  16  transfer address
- m0_wdata, m1_wdata  in  16  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- rdata  out  16  read data, shared by both masters, valid while the ackd master's ack=1
- io_address  out  16  bus address
- io_data_out  out  16  bus write data
- io_data_oe  out  1  1 = drive io_data (writes only)
- io_data_in  in  16  bus read data
- io_rd, io_wr  out  1  active-low strobes, never both low
- busy  out  1  transaction in progress (state ≠ IDLE)
- grant  out  1  index of the master owning the bus, valid while busy

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE.
- IDLE: if any req, select a winner, latch its we/addr/wdata, set grant, go to SETUP. Else stay.
- Arbitration is round-robin. Register last_grant resets to 1, so m0 wins the first tie. When both requesters are active, the one not served last wins. A single requester always wins.
- SETUP (1 cycle):
  - io_address = latched addr.
  - For writes: io_data_out = wdata and io_data_oe = 1.
  - Strobes stay high.
- STROBE (STROBE_CYCLES cycles): io_wr = 0 for a write, io_rd = 0 for a read. A down-counter counts the strobe cycles.
- Read sampling: rdata captures io_data_in at the edge that ends the last STROBE cycle.
- HOLD (1 cycle):
  - Strobes high; address, data and oe unchanged.
  - ack of the granted master = 1.
  - last_grant = grant.
- HOLD → IDLE at the next edge: oe → 0. io_address and io_data_out keep their value.
- Latched fields are immune to master input changes after acceptance.
- Master rule: at the edge where it samples ack = 1, the master drops req or presents a new transfer. IDLE samples the updated values.
- Reset values of outputs:
  - io_rd = io_wr = 1
  - io_data_oe = 0
  - io_address = io_data_out = rdata = 0
  - m0_ack = m1_ack = 0
  - busy = grant = 0
- Reset value of internal state: FSM IDLE, last_grant = 1, counter 0.
- Reset mid-transfer: strobes deassert immediately (asynchronous), the transfer is dropped, and no ack is issued.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Let A be the edge at which a request is accepted (IDLE→SETUP):
  - Strobe low from A+1 to A+1+STROBE_CYCLES.
  - Ack high from A+1+STROBE_CYCLES to A+2+STROBE_CYCLES.
  - Next acceptance possible at A+3+STROBE_CYCLES.
- Transfer period with continuous requests: STROBE_CYCLES+3 cycles; IDLE lasts a minimum of 1 cycle.
- Address and write data are stable for at least 1 cycle before the strobe falls and 1 cycle after it rises.
- Requests sampled outside IDLE are ignored; they are held pending.

## Structure
- Package io_bus_pkg holds:
  - State localparams ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD (2 bits).
  - Default STROBE_CYCLES.
  - Counter width $clog2(STROBE_CYCLES+1).
- Sub-module io_rr_arbiter: 2-way round-robin picker. Inputs req[1:0] and last_grant; outputs valid and winner. Combinational only.
- Sequencing FSM, latches and the strobe counter live in io_bus_arbiter.

## Test plan
- Reset: hold reset with m0_req = m1_req = 1 → all outputs at reset values, no strobe. After release, m0 is granted first.
- Write m0, addr 0x0012, wdata 0xBEEF, STROBE_CYCLES = 2:
  - io_wr low exactly 2 cycles, io_data_oe = 1 from SETUP through HOLD.
  - m0_ack pulses 1 cycle at A+3; bench RAM[0x0012] = 0xBEEF.
- Read m1, addr 0x0012 → io_rd low 2 cycles, io_data_oe = 0, rdata = 0xBEEF during m1_ack.
- Both requesting continuously → grants m0, m1, m0, m1, with acks spaced 5 cycles apart (STROBE_CYCLES = 2).
- Assert reset during the STROBE of a write → io_wr = 1 within the same timestep, no ack. After release with both requesting, m0 is granted.
- Change m0_addr to 0x0099 and m0_wdata to 0x1111 during SETUP of a write to 0x0012/0xBEEF → bus still shows 0x0012/0xBEEF through HOLD.
